// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//   Receives a program image over a byte stream and writes it into a 128-bit
//   wide instruction memory one 32-bit slot at a time. The core is held in
//   reset until the image is fully written.
//
//   Stream format: a 4-byte little-endian word count N. If 0 < N <= 65536, it
//   is followed by N little-endian 32-bit instruction words.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   rx_data    in   [7:0] received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   rx_ready   out  loader can take a byte (HDR / DATA)
//   stall      in   fetch stalled; a pending write waits while high
//   iw_we      out  instruction-memory write request (only in WRITE)
//   iw_addr    out  [13:0] bundle index = word index [15:2]
//   iw_slot    out  [1:0]  slot in bundle = word index [1:0]
//   iw_data    out  [31:0] instruction word
//   hold_core  out  high in every state except DONE
//   done       out  level, load finished
//   err        out  level, header count out of range
//   overrun    out  sticky, a byte arrived while rx_ready was low
//   tx_data    out  [7:0] status byte (AA = done, EE = error)
//   tx_valid   out  one-cycle strobe for tx_data
//   state_dbg  out  [2:0] current FSM state, for observation only
//
// Handshake: a byte is consumed on a rising edge where rx_valid and rx_ready
// are both high. A write is accepted on a rising edge where iw_we is high and
// stall is low; until then iw_we/iw_addr/iw_slot/iw_data hold steady.
// -----------------------------------------------------------------------------
module boot_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        stall,
   output logic        iw_we,
   output logic [13:0] iw_addr,
   output logic [1:0]  iw_slot,
   output logic [31:0] iw_data,
   output logic        hold_core,
   output logic        done,
   output logic        err,
   output logic        overrun,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] S_HDR   = 3'd0;
   localparam logic [2:0] S_DATA  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [31:0] MAX_WORDS = 32'd65536;

   logic [2:0]  state_q,    state_d;
   logic [1:0]  bcnt_q,     bcnt_d;
   logic [31:0] n_q,        n_d;
   logic [31:0] data_q,     data_d;
   logic [15:0] w_q,        w_d;
   logic        overrun_q,  overrun_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q,  tx_data_d;

   logic        take;
   logic [31:0] n_next;
   logic [31:0] data_next;

   // Status outputs decode directly from state, so an async reset in WRITE
   // drops iw_we without waiting for a clock.
   assign rx_ready  = (state_q == S_HDR) || (state_q == S_DATA);
   assign iw_we     = (state_q == S_WRITE);
   assign hold_core = (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign iw_addr   = w_q[15:2];
   assign iw_slot   = w_q[1:0];
   assign iw_data   = data_q;
   assign overrun   = overrun_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign state_dbg = state_q;

   assign take = rx_valid && rx_ready;

   always_comb begin
      // Incoming byte merged into its little-endian lane; the header decision
      // is made on the merged value so the transition happens at the 4th byte.
      n_next    = n_q;
      n_next[{bcnt_q, 3'b000} +: 8] = rx_data;
      data_next = data_q;
      data_next[{bcnt_q, 3'b000} +: 8] = rx_data;

      state_d    = state_q;
      bcnt_d     = bcnt_q;
      n_d        = n_q;
      data_d     = data_q;
      w_d        = w_q;
      overrun_d  = overrun_q | (rx_valid & ~rx_ready);
      tx_valid_d = 1'b0;
      tx_data_d  = tx_data_q;

      case (state_q)
         S_HDR: begin
            if (take) begin
               n_d    = n_next;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (n_next == 32'd0) begin
                     state_d    = S_DONE;
                     tx_valid_d = 1'b1;
                     tx_data_d  = 8'hAA;
                  end else if (n_next > MAX_WORDS) begin
                     state_d    = S_ERR;
                     tx_valid_d = 1'b1;
                     tx_data_d  = 8'hEE;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (take) begin
               data_d = data_next;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (!stall) begin
               w_d = w_q + 16'd1;
               // Compare in 32 bits: N may be 65536, one past W's range.
               if (({16'd0, w_q} + 32'd1) == n_q) begin
                  state_d    = S_DONE;
                  tx_valid_d = 1'b1;
                  tx_data_d  = 8'hAA;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_HDR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_HDR;
         bcnt_q     <= 2'd0;
         n_q        <= 32'd0;
         data_q     <= 32'd0;
         w_q        <= 16'd0;
         overrun_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         n_q        <= n_d;
         data_q     <= data_d;
         w_q        <= w_d;
         overrun_q  <= overrun_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//   Drives byte streams into boot_loader and checks the write sequence, status
//   pulses and level outputs against a reference built from the image itself:
//   word i of an N-word image must be written at bundle i/4, slot i%4.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        stall;
  logic        iw_we;
  logic [13:0] iw_addr;
  logic [1:0]  iw_slot;
  logic [31:0] iw_data;
  logic        hold_core;
  logic        done;
  logic        err;
  logic        overrun;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [2:0]  state_dbg;

  boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .stall     (stall),
    .iw_we     (iw_we),
    .iw_addr   (iw_addr),
    .iw_slot   (iw_slot),
    .iw_data   (iw_data),
    .hold_core (hold_core),
    .done      (done),
    .err       (err),
    .overrun   (overrun),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] words_a[0:15];

  bit   stall_rand  = 1'b0;
  logic stall_force = 1'b0;
  bit   gaps_en     = 1'b0;

  int          we_cycles = 0;
  int          stab_viol = 0;
  logic        pend      = 1'b0;
  logic [47:0] pend_w    = '0;

  // stall changes 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    stall = stall_rand ? ($urandom_range(0, 2) == 0) : stall_force;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (iw_we) begin
        we_cycles++;
        if (pend && ({iw_addr, iw_slot, iw_data} !== pend_w)) stab_viol++;
      end else if (pend) begin
        stab_viol++;
      end
      pend   = iw_we && stall;
      pend_w = {iw_addr, iw_slot, iw_data};
      if (iw_we && !stall) got_q.push_back({iw_addr, iw_slot, iw_data});
      if (tx_valid) tx_q.push_back(tx_data);
    end else begin
      pend = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_exp(input int n);
    logic [13:0] a;
    logic [1:0]  s;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = 14'(i / 4);
      s = 2'(i % 4);
      exp_q.push_back({a, s, words_a[i]});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst         = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'd0;
    stall_force = 1'b0;
    stall_rand  = 1'b0;
    gaps_en     = 1'b0;
    repeat (2) @(posedge clk);
    got_q.delete();
    tx_q.delete();
    #1;
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    int g;
    g = gaps_en ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    while (!rx_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic load(input int n, input int nw);
    send_word(32'(n));
    for (int i = 0; i < nw; i++) send_word(words_a[i]);
  endtask

  task automatic wait_term();
    int g = 0;
    while (!(done || err) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) words_a[i] = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if ({iw_we, iw_addr, iw_slot, iw_data} !== 49'd0) begin
      failures++;
      $display("FAIL reset_write_port got=%h exp=0", {iw_we, iw_addr, iw_slot, iw_data});
    end
    checks++;
    if ({hold_core, rx_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_hold_ready got=%b exp=11", {hold_core, rx_ready});
    end
    checks++;
    if ({done, err, overrun, tx_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=0000", {done, err, overrun, tx_valid});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data got=%h exp=00", tx_data);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    words_a[0] = 32'h11223344;
    words_a[1] = 32'hAABBCCDD;
    load(2, 2);
    wait_term();
    build_exp(2);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL basic_write_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({done, hold_core, err} !== 3'b100) begin
      failures++;
      $display("FAIL basic_done_hold_err got=%b exp=100", {done, hold_core, err});
    end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'hAA) begin
      failures++;
      $display("FAIL basic_tx got_n=%0d got0=%h exp=1 x AA", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
  endtask

  task automatic test_five();
    logic [47:0] fifth;
    do_reset();
    rand_words();
    stall_rand = 1'b1;
    gaps_en    = 1'b1;
    load(5, 5);
    wait_term();
    build_exp(5);
    checks++;
    if (got_q.size() !== 5) begin
      failures++;
      $display("FAIL five_write_count got=%0d exp=5", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL five_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    fifth = {14'd1, 2'd0, words_a[4]};
    checks++;
    if (got_q.size() < 5 || got_q[4] !== fifth) begin
      failures++;
      $display("FAIL five_fifth_addr got=%h exp=%h",
               (got_q.size() >= 5) ? got_q[4] : 48'h0, fifth);
    end
    checks++;
    if (stab_viol !== 0) begin
      failures++;
      $display("FAIL five_stall_stability got=%0d exp=0", stab_viol);
    end
  endtask

  task automatic test_stall();
    int w0;
    do_reset();
    words_a[0]  = $urandom;
    stall_force = 1'b1;
    load(1, 1);
    // now in the first WRITE cycle; keep stall high for three cycles
    w0 = we_cycles;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    stall_force = 1'b0;
    wait_term();
    checks++;
    if (we_cycles - w0 !== 4) begin
      failures++;
      $display("FAIL stall_we_cycles got=%0d exp=4", we_cycles - w0);
    end
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL stall_accept_count got=%0d exp=1", got_q.size());
    end
    checks++;
    if (stab_viol !== 0) begin
      failures++;
      $display("FAIL stall_stability got=%0d exp=0", stab_viol);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done got=%b exp=1", done);
    end
  endtask

  task automatic test_terminal();
    do_reset();
    load(0, 0);
    wait_term();
    checks++;
    if ({done, err, got_q.size() == 0} !== 3'b101) begin
      failures++;
      $display("FAIL zero_done_nowrite got=%b exp=101", {done, err, got_q.size() == 0});
    end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'hAA) begin
      failures++;
      $display("FAIL zero_tx got_n=%0d exp=1 x AA", tx_q.size());
    end
    // a byte in DONE is dropped, flags overrun, and DONE holds
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, overrun, hold_core} !== 3'b110) begin
      failures++;
      $display("FAIL done_terminal got=%b exp=110", {done, overrun, hold_core});
    end

    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    wait_term();
    checks++;
    if ({err, done, hold_core, rx_ready} !== 4'b1010) begin
      failures++;
      $display("FAIL big_err_levels got=%b exp=1010", {err, done, hold_core, rx_ready});
    end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'hEE) begin
      failures++;
      $display("FAIL big_tx got_n=%0d got0=%h exp=1 x EE", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    rand_words();
    stall_force = 1'b1;
    send_word(32'd3);
    send_word(words_a[0]);
    // first WRITE cycle, rx_ready low
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_before got=%b exp=0", overrun);
    end
    rx_valid = 1'b1;
    rx_data  = $urandom_range(0, 255);
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    stall_force = 1'b0;
    send_word(words_a[1]);
    send_word(words_a[2]);
    wait_term();
    build_exp(3);
    checks++;
    if (got_q.size() !== 3) begin
      failures++;
      $display("FAIL overrun_write_count got=%0d exp=3", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL overrun_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({overrun, done} !== 2'b11) begin
      failures++;
      $display("FAIL overrun_sticky got=%b exp=11", {overrun, done});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wrd;
    // reset while a write is pending
    do_reset();
    words_a[0]  = $urandom;
    stall_force = 1'b1;
    load(1, 1);
    #2;
    checks++;
    if (iw_we !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_we_before got=%b exp=1", iw_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({iw_we, iw_data} !== 33'd0) begin
      failures++;
      $display("FAIL midwrite_async_drop got=%h exp=0", {iw_we, iw_data});
    end

    // reset partway through a data word
    do_reset();
    send_word(32'd2);
    send_byte(8'h12);
    send_byte(8'h34);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, hold_core, iw_we, iw_data} !== {2'b11, 33'd0}) begin
      failures++;
      $display("FAIL middata_reset got=%h exp=%h", {rx_ready, hold_core, iw_we, iw_data},
               {2'b11, 33'd0});
    end
    do_reset();
    wrd        = $urandom;
    words_a[0] = wrd;
    load(1, 1);
    wait_term();
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== {14'd0, 2'd0, wrd}) begin
      failures++;
      $display("FAIL middata_fresh_load got_n=%0d got0=%h exp=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 48'h0, {14'd0, 2'd0, wrd});
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      rand_words();
      n          = $urandom_range(1, 16);
      stall_rand = 1'b1;
      gaps_en    = 1'b1;
      load(n, n);
      wait_term();
      build_exp(n);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_write_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write[%0d] got=%h exp=%h", it, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({done, hold_core, overrun} !== 3'b100 || tx_q.size() !== 1) begin
        failures++;
        $display("FAIL rand%0d_final got=%b tx_n=%0d exp=100 tx_n=1", it,
                 {done, hold_core, overrun}, tx_q.size());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_five();
    test_stall();
    test_terminal();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
